// File: rtl/stf_burst_gen.sv
// Short-training-field burst generator: streams NUM_REP periods of the 16-sample
// STF as a valid/ready I/Q stream, optionally followed by a half-amplitude tail.
module stf_burst_gen #(
  parameter int IQ_WIDTH = 16,
  parameter int NUM_REP  = 10,
  parameter int WIN_EN   = 1
) (
  input  logic                  clk,
  input  logic                  phy_tx_arest,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [2*IQ_WIDTH-1:0] s_data,
  output logic                  s_last,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  localparam int         SHIFT    = IQ_WIDTH - 16;
  localparam logic [3:0] LAST_REP = 4'(NUM_REP - 1);
  localparam logic       WIN      = (WIN_EN != 0);

  state_t                state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            rep_q, rep_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic [2*IQ_WIDTH-1:0] data_q, data_d;
  logic                  hs;

  function automatic logic [31:0] stf_entry(input logic [3:0] i);
    logic [31:0] e;
    case (i)
      4'd0:    e = 32'hfd0e_fd0e;
      4'd1:    e = 32'hfe68_fc27;
      4'd2:    e = 32'h0000_fbd6;
      4'd3:    e = 32'h0198_fc27;
      4'd4:    e = 32'h02f2_fd0e;
      4'd5:    e = 32'h03d9_fe68;
      4'd6:    e = 32'h042a_0000;
      4'd7:    e = 32'h03d9_0198;
      4'd8:    e = 32'h02f2_02f2;
      4'd9:    e = 32'h0198_03d9;
      4'd10:   e = 32'h0000_042a;
      4'd11:   e = 32'hfe68_03d9;
      4'd12:   e = 32'hfd0e_02f2;
      4'd13:   e = 32'hfc27_0198;
      4'd14:   e = 32'hfbd6_0000;
      default: e = 32'hfc27_fe68;
    endcase
    return e;
  endfunction

  function automatic logic signed [IQ_WIDTH-1:0] scale(input logic [15:0] v);
    logic signed [IQ_WIDTH-1:0] ext;
    ext = IQ_WIDTH'(signed'(v));
    return ext <<< SHIFT;
  endfunction

  // Arithmetic shift rounds toward negative infinity.
  function automatic logic signed [IQ_WIDTH-1:0] halve(input logic signed [IQ_WIDTH-1:0] v);
    return v >>> 1;
  endfunction

  function automatic logic [2*IQ_WIDTH-1:0] stf_sample(input state_t st, input logic [3:0] idx,
                                                       input logic [3:0] rep);
    logic [31:0]                e;
    logic signed [IQ_WIDTH-1:0] i_s;
    logic signed [IQ_WIDTH-1:0] q_s;
    if (st == TAIL || (idx == 4'd0 && rep == 4'd0)) begin
      e   = stf_entry(4'd0);
      i_s = halve(scale(e[31:16]));
      q_s = halve(scale(e[15:0]));
    end else begin
      e   = stf_entry(idx);
      i_s = scale(e[31:16]);
      q_s = scale(e[15:0]);
    end
    return {i_s, q_s};
  endfunction

  assign hs = valid_q && s_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      idx_d   = 4'd0;
      rep_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old burst.
          if (start && !done_q) begin
            state_d = RUN;
            idx_d   = 4'd0;
            rep_d   = 4'd0;
          end
        end
        RUN: begin
          if (hs) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              rep_d = rep_q + 4'd1;
              if (rep_q == LAST_REP) begin
                rep_d   = 4'd0;
                state_d = WIN ? TAIL : IDLE;
                done_d  = !WIN;
              end
            end
          end
        end
        TAIL: begin
          if (hs) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (state_d != IDLE);
    data_d  = valid_d ? stf_sample(state_d, idx_d, rep_d) : '0;
    last_d  = (state_d == TAIL) ||
              (state_d == RUN && !WIN && idx_d == 4'd15 && rep_d == LAST_REP);
  end

  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      rep_q   <= 4'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign s_valid = valid_q;
  assign s_data  = data_q;
  assign s_last  = last_q;
  assign done    = done_q;

endmodule

// File: tb/tb_stf_burst_gen.sv
// Directed bench for stf_burst_gen: three parameterisations sharing one clock,
// stream capture with optional random back-pressure, and corner-case sequences.
module tb_stf_burst_gen;

  typedef struct {
    int          n;
    logic [47:0] data;
    logic        last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b1;
  int   sel = 0;

  logic st0, st1, st2;
  logic d0_busy, d0_valid, d0_last, d0_done;
  logic d1_busy, d1_valid, d1_last, d1_done;
  logic d2_busy, d2_valid, d2_last, d2_done;
  logic [31:0] d0_data, d1_data;
  logic [35:0] d2_data;

  logic        obs_busy, obs_valid, obs_last, obs_done;
  logic [47:0] obs_data;

  int passed = 0;
  int total = 0;
  int stab_err = 0;

  logic [47:0] got_d[$];
  logic        got_l[$];

  logic [31:0] tbl [16] = '{
    32'hfd0efd0e, 32'hfe68fc27, 32'h0000fbd6, 32'h0198fc27,
    32'h02f2fd0e, 32'h03d9fe68, 32'h042a0000, 32'h03d90198,
    32'h02f202f2, 32'h019803d9, 32'h0000042a, 32'hfe6803d9,
    32'hfd0e02f2, 32'hfc270198, 32'hfbd60000, 32'hfc27fe68};

  vec_t vdef [7];
  vec_t vnw  [5];

  always #5 clk = ~clk;

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  stf_burst_gen u_def (
    .clk(clk), .phy_tx_arest(rst), .start(st0), .abort(abort), .busy(d0_busy),
    .s_valid(d0_valid), .s_ready(ready), .s_data(d0_data), .s_last(d0_last), .done(d0_done));

  stf_burst_gen #(.IQ_WIDTH(16), .NUM_REP(2), .WIN_EN(0)) u_nw (
    .clk(clk), .phy_tx_arest(rst), .start(st1), .abort(abort), .busy(d1_busy),
    .s_valid(d1_valid), .s_ready(ready), .s_data(d1_data), .s_last(d1_last), .done(d1_done));

  stf_burst_gen #(.IQ_WIDTH(18), .NUM_REP(1), .WIN_EN(1)) u_w18 (
    .clk(clk), .phy_tx_arest(rst), .start(st2), .abort(abort), .busy(d2_busy),
    .s_valid(d2_valid), .s_ready(ready), .s_data(d2_data), .s_last(d2_last), .done(d2_done));

  always_comb begin
    obs_busy  = d0_busy;
    obs_valid = d0_valid;
    obs_last  = d0_last;
    obs_done  = d0_done;
    obs_data  = {16'h0, d0_data};
    if (sel == 1) begin
      obs_busy  = d1_busy;
      obs_valid = d1_valid;
      obs_last  = d1_last;
      obs_done  = d1_done;
      obs_data  = {16'h0, d1_data};
    end else if (sel == 2) begin
      obs_busy  = d2_busy;
      obs_valid = d2_valid;
      obs_last  = d2_last;
      obs_done  = d2_done;
      obs_data  = {12'h0, d2_data};
    end
  end

  function automatic logic [47:0] exp_def(input int n);
    if (n == 0 || n == 160) return 48'h0000fe87fe87;
    return {16'h0, tbl[n % 16]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic start_burst();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Capture handshaken samples from the selected DUT, starting at a negedge.
  task automatic collect(input int max_hs, input int start_at, input bit rnd, output bit tmo);
    bit          stall = 1'b0;
    bit          fin = 1'b0;
    logic [47:0] pd = '0;
    logic        pl = 1'b0;
    tmo = 1'b1;
    got_d.delete();
    got_l.delete();
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (stall && (obs_valid !== 1'b1 || obs_data !== pd || obs_last !== pl)) stab_err++;
      ready = rnd ? ($urandom_range(0, 99) < 40) : 1'b1;
      start = (start_at >= 0 && got_d.size() == start_at);
      stall = obs_valid && !ready;
      pd    = obs_data;
      pl    = obs_last;
      if (obs_valid && ready) begin
        got_d.push_back(obs_data);
        got_l.push_back(obs_last);
        if (obs_last || got_d.size() == max_hs) begin
          fin = 1'b1;
          tmo = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    ready = (max_hs > 0) ? 1'b0 : 1'b1;
  endtask

  function automatic int mism_def();
    int m = 0;
    if (got_d.size() != 161) m++;
    for (int i = 0; i < got_d.size() && i < 161; i++) begin
      if (got_d[i] !== exp_def(i)) m++;
      if (got_l[i] !== (i == 160)) m++;
    end
    return m;
  endfunction

  task automatic check_vecs(input string tag, input vec_t v);
    if (v.n < got_d.size()) begin
      chk($sformatf("%s_data[%0d]", tag, v.n), {16'h0, got_d[v.n]}, {16'h0, v.data});
      chk($sformatf("%s_last[%0d]", tag, v.n), {63'h0, got_l[v.n]}, {63'h0, v.last});
    end else begin
      chk($sformatf("%s_missing[%0d]", tag, v.n), 64'(got_d.size()), 64'(v.n + 1));
    end
  endtask

  initial begin
    bit tmo;
    vdef = '{
      '{0,   48'hfe87fe87, 1'b0}, '{1,   48'hfe68fc27, 1'b0}, '{15,  48'hfc27fe68, 1'b0},
      '{16,  48'hfd0efd0e, 1'b0}, '{50,  48'h0000fbd6, 1'b0}, '{159, 48'hfc27fe68, 1'b0},
      '{160, 48'hfe87fe87, 1'b1}};
    vnw = '{
      '{0,  48'hfe87fe87, 1'b0}, '{1,  48'hfe68fc27, 1'b0}, '{16, 48'hfd0efd0e, 1'b0},
      '{30, 48'hfbd60000, 1'b0}, '{31, 48'hfc27fe68, 1'b1}};

    repeat (3) @(negedge clk);
    chk("rst_valid", {63'h0, d0_valid}, 64'h0);
    chk("rst_busy",  {63'h0, d0_busy},  64'h0);
    chk("rst_data",  {32'h0, d0_data},  64'h0);
    chk("rst_last",  {63'h0, d0_last},  64'h0);
    chk("rst_done",  {63'h0, d0_done},  64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Defaults, full-rate
    sel = 0;
    chk("idle_valid_before_start", {63'h0, obs_valid}, 64'h0);
    start_burst();
    chk("latency_valid", {63'h0, obs_valid}, 64'h1);
    chk("latency_busy",  {63'h0, obs_busy},  64'h1);
    collect(-1, -1, 1'b0, tmo);
    chk("def_timeout", {63'h0, tmo}, 64'h0);
    chk("def_count", 64'(got_d.size()), 64'd161);
    for (int i = 0; i < 7; i++) check_vecs("def", vdef[i]);
    chk("def_stream", 64'(mism_def()), 64'h0);
    chk("def_done", {63'h0, obs_done}, 64'h1);
    chk("def_busy_at_done", {63'h0, obs_busy}, 64'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_done_valid", {63'h0, obs_valid}, 64'h0);
    chk("start_at_done_busy",  {63'h0, obs_busy},  64'h0);
    chk("done_one_cycle",      {63'h0, obs_done},  64'h0);
    @(negedge clk);
    chk("start_at_done_still_idle", {63'h0, obs_valid}, 64'h0);

    // Random back-pressure
    start_burst();
    stab_err = 0;
    collect(-1, -1, 1'b1, tmo);
    chk("rnd_timeout", {63'h0, tmo}, 64'h0);
    chk("rnd_stream", 64'(mism_def()), 64'h0);
    chk("rnd_stable", 64'(stab_err), 64'h0);
    repeat (2) @(negedge clk);

    // Start while busy at sample 20
    start_burst();
    collect(-1, 20, 1'b0, tmo);
    chk("busy_start_timeout", {63'h0, tmo}, 64'h0);
    chk("busy_start_stream", 64'(mism_def()), 64'h0);
    repeat (2) @(negedge clk);

    // Abort at sample 50
    start_burst();
    collect(50, -1, 1'b0, tmo);
    chk("abort_pre_timeout", {63'h0, tmo}, 64'h0);
    chk("abort_pre_data", {16'h0, obs_data}, {16'h0, exp_def(50)});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ready = 1'b1;
    chk("abort_valid", {63'h0, obs_valid}, 64'h0);
    chk("abort_busy",  {63'h0, obs_busy},  64'h0);
    chk("abort_last",  {63'h0, obs_last},  64'h0);
    chk("abort_done",  {63'h0, obs_done},  64'h0);
    @(negedge clk);
    chk("abort_no_done_later", {63'h0, obs_done}, 64'h0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle_valid", {63'h0, obs_valid}, 64'h0);
    chk("abort_start_idle_busy",  {63'h0, obs_busy},  64'h0);
    @(negedge clk);
    start_burst();
    collect(-1, -1, 1'b0, tmo);
    chk("abort_fresh_timeout", {63'h0, tmo}, 64'h0);
    chk("abort_fresh_stream", 64'(mism_def()), 64'h0);
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-burst
    start_burst();
    collect(30, -1, 1'b0, tmo);
    chk("arst_pre_valid", {63'h0, obs_valid}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'h0, d0_valid}, 64'h0);
    chk("arst_busy",  {63'h0, d0_busy},  64'h0);
    chk("arst_data",  {32'h0, d0_data},  64'h0);
    chk("arst_last",  {63'h0, d0_last},  64'h0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    chk("arst_after_valid", {63'h0, d0_valid}, 64'h0);

    // WIN_EN=0, NUM_REP=2
    sel = 1;
    start_burst();
    collect(-1, -1, 1'b0, tmo);
    chk("nw_timeout", {63'h0, tmo}, 64'h0);
    chk("nw_count", 64'(got_d.size()), 64'd32);
    for (int i = 0; i < 5; i++) check_vecs("nw", vnw[i]);
    chk("nw_done", {63'h0, obs_done}, 64'h1);
    chk("nw_busy_at_done", {63'h0, obs_busy}, 64'h0);
    repeat (2) @(negedge clk);

    // IQ_WIDTH=18, NUM_REP=1
    sel = 2;
    start_burst();
    collect(-1, -1, 1'b0, tmo);
    chk("w18_timeout", {63'h0, tmo}, 64'h0);
    chk("w18_count", 64'(got_d.size()), 64'd17);
    if (got_d.size() == 17) begin
      chk("w18_s0",     {16'h0, got_d[0]},  {28'h0, 18'h3fa1c, 18'h3fa1c});
      chk("w18_s6",     {16'h0, got_d[6]},  {28'h0, 18'h010a8, 18'h00000});
      chk("w18_s14_i",  {46'h0, got_d[14][35:18]}, {46'h0, 18'h3ef58});
      chk("w18_tail",   {16'h0, got_d[16]}, {28'h0, 18'h3fa1c, 18'h3fa1c});
      chk("w18_last",   {63'h0, got_l[16]}, 64'h1);
    end
    chk("w18_done", {63'h0, obs_done}, 64'h1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
